// File: rtl/reg_bus_regfile_pkg.sv
// Shared types and helpers for the register-bus responder.
package reg_bus_regfile_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    localparam int unsigned LOCK_BIT = 0;

    function automatic int unsigned idx_w(input int unsigned n);
        idx_w = (n < 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/reg_bus_regfile_decode.sv
// Combinational address decode: register index, alignment, range and read-only hit.
module reg_bus_regfile_decode
    import reg_bus_regfile_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic [ADDR_WIDTH-1:0]          addr_i,
    output logic [idx_w(NUM_REGS)-1:0]     index_o,
    output logic                           misaligned_o,
    output logic                           out_of_range_o,
    output logic                           ro_hit_o
);

    localparam int unsigned IW  = idx_w(NUM_REGS);
    localparam int unsigned OFS = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFS) - 1);

    assign index_o        = addr_i[OFS +: IW];
    assign misaligned_o   = |(addr_i & ALIGN_MASK);
    // Any bit above the index field selects a non-existent register.
    assign out_of_range_o = |(addr_i >> (OFS + IW));
    assign ro_hit_o       = RO_MASK[index_o];

endmodule

// File: rtl/reg_bus_regfile.sv
// Register-bus responder: NUM_REGS registers with byte strobes, wait states and error reporting.
// Optional sticky lock register enabled by defining REG_BUS_REGFILE_LOCK_EN.
module reg_bus_regfile
    import reg_bus_regfile_pkg::*;
#(
    parameter int unsigned                      ADDR_WIDTH  = 32,
    parameter int unsigned                      DATA_WIDTH  = 32,
    parameter int unsigned                      NUM_REGS    = 16,
    parameter int unsigned                      WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]              RO_MASK     = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL   = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [ADDR_WIDTH-1:0]           reg_addr_i,
    input  logic                            reg_write_i,
    input  logic [DATA_WIDTH-1:0]           reg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]         reg_wstrb_i,
    input  logic                            reg_valid_i,
    output logic [DATA_WIDTH-1:0]           reg_rdata_o,
    output logic                            reg_error_o,
    output logic                            reg_ready_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_q_o,
    input  logic [NUM_REGS-1:0]             hw_we_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]  hw_wdata_i
);

    localparam int unsigned IW = idx_w(NUM_REGS);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [IW-1:0]         idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  ro_hit;
    logic                  lock_blk;
    logic                  err_c;
    logic                  ready;
    logic                  commit;
    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    reg_bus_regfile_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_decode (
        .addr_i         (reg_addr_i),
        .index_o        (idx),
        .misaligned_o   (misaligned),
        .out_of_range_o (out_of_range),
        .ro_hit_o       (ro_hit)
    );

`ifdef REG_BUS_REGFILE_LOCK_EN
    localparam int unsigned LOCK_IDX = NUM_REGS - 1;
    // Once locked, only the lock register itself stays bus-writable.
    assign lock_blk = reg_write_i && regs_q[LOCK_IDX][LOCK_BIT] && (idx != IW'(LOCK_IDX));
`else
    assign lock_blk = 1'b0;
`endif

    assign err_c  = misaligned || out_of_range || (reg_write_i && ro_hit) || lock_blk;
    assign commit = ready && reg_write_i && !err_c;

    always_comb begin
        ready = 1'b0;
        if (WAIT_CYCLES == 0) begin
            ready = reg_valid_i;
        end else begin
            ready = (state_q == WAIT) && reg_valid_i && (cnt_q == 4'(WAIT_CYCLES));
        end
    end

    assign reg_ready_o = ready;
    assign reg_error_o = ready && err_c;
    assign reg_rdata_o = (ready && !reg_write_i && !err_c) ? regs_q[idx] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reg_valid_i && (WAIT_CYCLES != 0)) begin
                        state_q <= WAIT;
                        cnt_q   <= 4'd1;
                    end
                end
                WAIT: begin
                    if (!reg_valid_i || ready) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Hardware load first, then bus bytes on top so the bus wins a collision.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            if (hw_we_i[k]) begin
                regs_d[k] = hw_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (commit && (idx == IW'(k)) && !RO_MASK[k]) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (reg_wstrb_i[b]) begin
                        regs_d[k][b*8 +: 8] = reg_wdata_i[b*8 +: 8];
                    end
                end
            end
        end
`ifdef REG_BUS_REGFILE_LOCK_EN
        regs_d[LOCK_IDX][LOCK_BIT] = regs_d[LOCK_IDX][LOCK_BIT] | regs_q[LOCK_IDX][LOCK_BIT];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    a_valid_held_in_wait: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == WAIT) |-> reg_valid_i
    );

endmodule
